// File: rtl/ad_avg.sv
// Dual-channel boxcar averaging decimator: sums 2**AVG_LOG2 samples per channel
// and emits the floored mean with a one-cycle strobe and a rail-hit flag.
module ad_avg #(
    parameter int unsigned DW       = 12,
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic          clk50m,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] ad_ch1,
    input  logic [DW-1:0] ad_ch2,
    output logic [DW-1:0] avg_ch1,
    output logic [DW-1:0] avg_ch2,
    output logic          avg_valid,
    output logic          ovr_ch1,
    output logic          ovr_ch2
);

    localparam int unsigned AW = DW + AVG_LOG2;
    localparam int unsigned CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CW-1:0] LAST = CW'((2 ** AVG_LOG2) - 1);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t        state_q;
    logic [AW-1:0] acc1_q, acc2_q;
    logic [CW-1:0] cnt_q;
    logic          r1_q, r2_q;
    logic [DW-1:0] avg1_q, avg2_q;
    logic          valid_q, ovr1_q, ovr2_q;

    logic [AW-1:0] base1, base2, sum1_d, sum2_d;
    logic [CW-1:0] cnt_eff;
    logic          r1_eff, r2_eff, rail1, rail2, last;

    // IDLE always starts from an empty window, so the sample seen there is sample 0.
    always_comb begin
        base1   = '0;
        base2   = '0;
        cnt_eff = '0;
        r1_eff  = 1'b0;
        r2_eff  = 1'b0;
        if (state_q == ACC) begin
            base1   = acc1_q;
            base2   = acc2_q;
            cnt_eff = cnt_q;
            r1_eff  = r1_q;
            r2_eff  = r2_q;
        end
        sum1_d = base1 + AW'(ad_ch1);
        sum2_d = base2 + AW'(ad_ch2);
        rail1  = (ad_ch1 == '0) || (ad_ch1 == '1);
        rail2  = (ad_ch2 == '0) || (ad_ch2 == '1);
        last   = (cnt_eff == LAST);
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            state_q <= IDLE;
            acc1_q  <= '0;
            acc2_q  <= '0;
            cnt_q   <= '0;
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
            avg1_q  <= '0;
            avg2_q  <= '0;
            valid_q <= 1'b0;
            ovr1_q  <= 1'b0;
            ovr2_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                acc1_q  <= '0;
                acc2_q  <= '0;
                cnt_q   <= '0;
                r1_q    <= 1'b0;
                r2_q    <= 1'b0;
            end else if (last) begin
                // Window complete: publish and start the next window with no gap.
                state_q <= ACC;
                avg1_q  <= sum1_d[AW-1:AVG_LOG2];
                avg2_q  <= sum2_d[AW-1:AVG_LOG2];
                ovr1_q  <= r1_eff | rail1;
                ovr2_q  <= r2_eff | rail2;
                valid_q <= 1'b1;
                acc1_q  <= '0;
                acc2_q  <= '0;
                cnt_q   <= '0;
                r1_q    <= 1'b0;
                r2_q    <= 1'b0;
            end else begin
                state_q <= ACC;
                acc1_q  <= sum1_d;
                acc2_q  <= sum2_d;
                cnt_q   <= cnt_eff + CW'(1);
                r1_q    <= r1_eff | rail1;
                r2_q    <= r2_eff | rail2;
            end
        end
    end

    assign avg_ch1   = avg1_q;
    assign avg_ch2   = avg2_q;
    assign avg_valid = valid_q;
    assign ovr_ch1   = ovr1_q;
    assign ovr_ch2   = ovr2_q;

endmodule

// File: tb/tb_ad_avg.sv
// Directed bench for ad_avg: a 16-sample build and a pass-through (AVG_LOG2=0) build.
module tb_ad_avg;

    logic        clk50m = 1'b0;
    logic        reset;
    logic        en, en0;
    logic [11:0] ch1, ch2, ch1_0, ch2_0;
    logic [11:0] avg1, avg2, avg1_0, avg2_0;
    logic        vld, ovr1, ovr2, vld0, ovr1_0, ovr2_0;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk50m = ~clk50m;

    ad_avg #(.DW(12), .AVG_LOG2(4)) u_dut (
        .clk50m(clk50m), .reset(reset), .en(en), .ad_ch1(ch1), .ad_ch2(ch2),
        .avg_ch1(avg1), .avg_ch2(avg2), .avg_valid(vld), .ovr_ch1(ovr1), .ovr_ch2(ovr2)
    );

    ad_avg #(.DW(12), .AVG_LOG2(0)) u_dut0 (
        .clk50m(clk50m), .reset(reset), .en(en0), .ad_ch1(ch1_0), .ad_ch2(ch2_0),
        .avg_ch1(avg1_0), .avg_ch2(avg2_0), .avg_valid(vld0), .ovr_ch1(ovr1_0), .ovr_ch2(ovr2_0)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Outputs are inspected 1 time unit after the edge that consumed the inputs.
    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    // Runs one full 16-sample window with constant inputs; strobe only on the last edge.
    task automatic window16(input string tag, input logic [11:0] a, input logic [11:0] b);
        ch1 = a;
        ch2 = b;
        for (int i = 0; i < 16; i++) begin
            tick();
            check({tag, "_vld"}, vld, (i == 15) ? 1 : 0);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; en0 = 1'b0;
        ch1 = '0; ch2 = '0; ch1_0 = '0; ch2_0 = '0;
        #2;
        tick();
        tick();
        check("rst_avg1", avg1, 0);
        check("rst_avg2", avg2, 0);
        check("rst_vld", vld, 0);
        check("rst_ovr1", ovr1, 0);
        check("rst_ovr2", ovr2, 0);
        check("rst_vld0", vld0, 0);

        // 1: constant mid-scale, strobes every 16 cycles
        reset = 1'b0;
        en    = 1'b1;
        ch1   = 12'd2048;
        ch2   = 12'd2048;
        for (int i = 0; i < 48; i++) begin
            tick();
            check("t1_vld", vld, ((i % 16) == 15) ? 1 : 0);
            if ((i % 16) == 15) begin
                check("t1_avg1", avg1, 2048);
                check("t1_avg2", avg2, 2048);
                check("t1_ovr1", ovr1, 0);
                check("t1_ovr2", ovr2, 0);
            end
        end

        // 2: ramp 0..15 on ch1, floor(120/16)=7, sample 0 is a rail
        ch2 = 12'd100;
        for (int i = 0; i < 16; i++) begin
            ch1 = 12'(i);
            tick();
            check("t2_vld", vld, (i == 15) ? 1 : 0);
        end
        check("t2_avg1", avg1, 7);
        check("t2_ovr1", ovr1, 1);
        check("t2_avg2", avg2, 100);
        check("t2_ovr2", ovr2, 0);

        // 3: full scale, no accumulator wrap
        window16("t3", 12'd4095, 12'd4095);
        check("t3_avg1", avg1, 4095);
        check("t3_avg2", avg2, 4095);
        check("t3_ovr1", ovr1, 1);
        check("t3_ovr2", ovr2, 1);

        // 4: abort after 10 samples, outputs hold, fresh window after en returns
        ch1 = 12'd1000;
        ch2 = 12'd1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_part_vld", vld, 0);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_off_vld", vld, 0);
        end
        check("t4_hold_avg1", avg1, 4095);
        check("t4_hold_ovr1", ovr1, 1);
        en = 1'b1;
        window16("t4", 12'd1000, 12'd1000);
        check("t4_avg1", avg1, 1000);
        check("t4_ovr1", ovr1, 0);

        // 4b: en drops exactly on the would-be 16th sample
        ch1 = 12'd300;
        for (int i = 0; i < 15; i++) tick();
        en = 1'b0;
        tick();
        check("t4b_vld", vld, 0);
        check("t4b_hold_avg1", avg1, 1000);
        en = 1'b1;

        // 5: reset mid-window after a result of 500; ch2 rail must not leak across reset
        window16("t5a", 12'd500, 12'd200);
        check("t5_pre_avg1", avg1, 500);
        ch2 = 12'd0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        tick();
        check("t5_rst_avg1", avg1, 0);
        check("t5_rst_vld", vld, 0);
        check("t5_rst_ovr2", ovr2, 0);
        reset = 1'b0;
        window16("t5b", 12'd600, 12'd200);
        check("t5_avg1", avg1, 600);
        check("t5_avg2", avg2, 200);
        check("t5_ovr2", ovr2, 0);

        // 6: pass-through build
        en    = 1'b0;
        en0   = 1'b1;
        ch2_0 = 12'd7;
        ch1_0 = 12'd5;
        tick();
        check("t6_avg_a", avg1_0, 5);
        check("t6_vld_a", vld0, 1);
        check("t6_ovr_a", ovr1_0, 0);
        ch1_0 = 12'd9;
        tick();
        check("t6_avg_b", avg1_0, 9);
        check("t6_vld_b", vld0, 1);
        check("t6_ovr_b", ovr1_0, 0);
        ch1_0 = 12'd4095;
        tick();
        check("t6_avg_c", avg1_0, 4095);
        check("t6_vld_c", vld0, 1);
        check("t6_ovr_c", ovr1_0, 1);
        check("t6_avg2", avg2_0, 7);
        check("t6_ovr2", ovr2_0, 0);
        en0   = 1'b0;
        ch1_0 = 12'd33;
        tick();
        check("t6_off_vld", vld0, 0);
        check("t6_off_hold", avg1_0, 4095);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
